// File: rtl/reg_file_mp_if.sv
// Bus interface for reg_file_mp: read selects/data, req/ack write ports, init status.
// The requester side uses the master modport and the register file uses the slave modport.
interface reg_file_mp_if #(
    parameter int NUM_REGS     = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_RD_PORTS = 2,
    parameter int NUM_WR_PORTS = 2
);
    localparam int SEL_W = $clog2(NUM_REGS);

    logic [NUM_RD_PORTS*SEL_W-1:0]      rd_sel;
    logic [NUM_RD_PORTS*DATA_WIDTH-1:0] rd_data;
    logic [NUM_WR_PORTS-1:0]            wr_req;
    logic [NUM_WR_PORTS*SEL_W-1:0]      wr_sel;
    logic [NUM_WR_PORTS*DATA_WIDTH-1:0] wr_data;
    logic [NUM_WR_PORTS-1:0]            wr_ack;
    logic                               init_done;

    modport master (
        output rd_sel, wr_req, wr_sel, wr_data,
        input  rd_data, wr_ack, init_done
    );

    modport slave (
        input  rd_sel, wr_req, wr_sel, wr_data,
        output rd_data, wr_ack, init_done
    );
endinterface

// File: rtl/reg_file_mp.sv
// Multi-port register file with priority write arbitration, hardwired-zero r0 and post-reset clear.
// Define REG_FILE_MP_BYPASS_EN to forward same-cycle granted write data onto matching read ports.
module reg_file_mp #(
    parameter int NUM_REGS     = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_RD_PORTS = 2,
    parameter int NUM_WR_PORTS = 2
) (
    input  logic             clk,
    input  logic             rst,
    reg_file_mp_if.slave     bus
);
    localparam int SEL_W = $clog2(NUM_REGS);

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    state_t                  state_q, state_d;
    logic [SEL_W-1:0]        cnt_q, cnt_d;
    logic                    init_done_q, init_done_d;
    logic [NUM_WR_PORTS-1:0] wr_ack_q, wr_ack_d;
    logic [NUM_WR_PORTS-1:0] elig, grant;

    logic [DATA_WIDTH-1:0]   regs_q [NUM_REGS];
    logic [SEL_W-1:0]        wsel   [NUM_WR_PORTS];
    logic [DATA_WIDTH-1:0]   wdata  [NUM_WR_PORTS];
    logic [SEL_W-1:0]        rsel   [NUM_RD_PORTS];
    logic [DATA_WIDTH-1:0]   rval   [NUM_RD_PORTS];
    logic [NUM_RD_PORTS*DATA_WIDTH-1:0] rd_data_c;

    always_comb begin
        for (int unsigned i = 0; i < NUM_WR_PORTS; i++) begin
            wsel[i]  = bus.wr_sel[i*SEL_W +: SEL_W];
            wdata[i] = bus.wr_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
        for (int unsigned p = 0; p < NUM_RD_PORTS; p++) begin
            rsel[p] = bus.rd_sel[p*SEL_W +: SEL_W];
        end
    end

    // A port whose ack is showing is ineligible, so a held request cannot win twice
    // and a same-register loser gets through on the winner's ack cycle.
    always_comb begin
        elig  = bus.wr_req & ~wr_ack_q;
        grant = '0;
        for (int unsigned i = 0; i < NUM_WR_PORTS; i++) begin
            grant[i] = elig[i] && (state_q == ST_RUN);
            for (int unsigned j = 0; j < i; j++) begin
                if (elig[j] && (wsel[j] == wsel[i])) begin
                    grant[i] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        init_done_d = init_done_q;
        wr_ack_d    = '0;
        case (state_q)
            ST_CLEAR: begin
                cnt_d = cnt_q + SEL_W'(1);
                if (cnt_q == SEL_W'(NUM_REGS - 1)) begin
                    state_d     = ST_RUN;
                    init_done_d = 1'b1;
                end
            end
            ST_RUN: begin
                wr_ack_d = grant;
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_CLEAR;
            cnt_q       <= SEL_W'(1);
            init_done_q <= 1'b0;
            wr_ack_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_done_q <= init_done_d;
            wr_ack_q    <= wr_ack_d;
        end
    end

    // r0 may be written but is masked on read; grants never collide on one register.
    always_ff @(posedge clk) begin
        if (state_q == ST_CLEAR) begin
            regs_q[cnt_q] <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_WR_PORTS; i++) begin
                if (grant[i]) begin
                    regs_q[wsel[i]] <= wdata[i];
                end
            end
        end
    end

    always_comb begin
        rd_data_c = '0;
        for (int unsigned p = 0; p < NUM_RD_PORTS; p++) begin
            rval[p] = '0;
            if (init_done_q && (rsel[p] != '0)) begin
                rval[p] = regs_q[rsel[p]];
`ifdef REG_FILE_MP_BYPASS_EN
                for (int unsigned i = 0; i < NUM_WR_PORTS; i++) begin
                    if (grant[i] && (wsel[i] == rsel[p])) begin
                        rval[p] = wdata[i];
                    end
                end
`else
`endif
            end
            rd_data_c[p*DATA_WIDTH +: DATA_WIDTH] = rval[p];
        end
    end

    assign bus.rd_data   = rd_data_c;
    assign bus.wr_ack    = wr_ack_q;
    assign bus.init_done = init_done_q;
endmodule

// File: tb/tb_reg_file_mp.sv
// Directed self-checking bench for reg_file_mp (32 x 32, 2 read / 2 write ports).
// Expectations follow REG_FILE_MP_BYPASS_EN when it is defined for the build.
module tb_reg_file_mp;
    localparam int NR  = 32;
    localparam int DW  = 32;
    localparam int NRP = 2;
    localparam int NWP = 2;
    localparam int SW  = 5;

    logic clk;
    logic rst;
    int   tests;
    int   fails;
    int   n;
    logic ack_seen;

    reg_file_mp_if #(.NUM_REGS(NR), .DATA_WIDTH(DW), .NUM_RD_PORTS(NRP), .NUM_WR_PORTS(NWP)) bus ();

    reg_file_mp #(.NUM_REGS(NR), .DATA_WIDTH(DW), .NUM_RD_PORTS(NRP), .NUM_WR_PORTS(NWP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic set_wr(input int p, input logic req, input logic [4:0] sel, input logic [31:0] d);
        bus.wr_req[p]           = req;
        bus.wr_sel[p*SW +: SW]  = sel;
        bus.wr_data[p*DW +: DW] = d;
    endtask

    task automatic set_rd(input int p, input logic [4:0] sel);
        bus.rd_sel[p*SW +: SW] = sel;
    endtask

    function automatic logic [31:0] rd(input int p);
        return bus.rd_data[p*DW +: DW];
    endfunction

    task automatic wait_init(output int cnt, output logic seen);
        cnt  = 0;
        seen = 1'b0;
        while (!bus.init_done && cnt < 100) begin
            tick();
            cnt++;
            if (bus.wr_ack != '0) seen = 1'b1;
        end
    endtask

    task automatic wr_single(input int p, input logic [4:0] sel, input logic [31:0] d);
        int k;
        set_wr(p, 1'b1, sel, d);
        k = 0;
        do begin
            tick();
            k++;
        end while (bus.wr_ack[p] !== 1'b1 && k < 20);
        check("single_ack", {31'b0, bus.wr_ack[p]}, 32'd1);
        set_wr(p, 1'b0, sel, d);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        bus.rd_sel  = '0;
        bus.wr_req  = '0;
        bus.wr_sel  = '0;
        bus.wr_data = '0;
        tick(); tick(); tick();

        // Reset state
        set_rd(0, 5'd5);
        set_rd(1, 5'd31);
        #1;
        check("rst_init_done", {31'b0, bus.init_done}, 32'd0);
        check("rst_ack", {30'b0, bus.wr_ack}, 32'd0);
        check("rst_rd0", rd(0), 32'h0);
        check("rst_rd1", rd(1), 32'h0);

        rst = 1'b0;
        wait_init(n, ack_seen);
        check("clear1_len", n, 32'd31);
        check("clear1_no_ack", {31'b0, ack_seen}, 32'd0);

        // Parallel writes to distinct registers
        set_rd(0, 5'd5);
        set_rd(1, 5'd9);
        set_wr(0, 1'b1, 5'd5, 32'hDEADBEEF);
        set_wr(1, 1'b1, 5'd9, 32'h12345678);
        #1;
`ifdef REG_FILE_MP_BYPASS_EN
        check("par_same_rd0", rd(0), 32'hDEADBEEF);
        check("par_same_rd1", rd(1), 32'h12345678);
`else
        check("par_same_rd0", rd(0), 32'h0);
        check("par_same_rd1", rd(1), 32'h0);
`endif
        tick();
        check("par_ack", {30'b0, bus.wr_ack}, 32'd3);
        check("par_rd0", rd(0), 32'hDEADBEEF);
        check("par_rd1", rd(1), 32'h12345678);
        set_wr(0, 1'b0, 5'd5, 32'hDEADBEEF);
        set_wr(1, 1'b0, 5'd9, 32'h12345678);
        tick();
        check("par_ack_clr", {30'b0, bus.wr_ack}, 32'd0);

        // Same-register conflict: port 0 wins first, port 1 next cycle
        set_rd(0, 5'd7);
        set_wr(0, 1'b1, 5'd7, 32'h00001111);
        set_wr(1, 1'b1, 5'd7, 32'h00002222);
        tick();
        check("conf_ack1", {30'b0, bus.wr_ack}, 32'd1);
`ifdef REG_FILE_MP_BYPASS_EN
        check("conf_rd_mid", rd(0), 32'h00002222);
`else
        check("conf_rd_mid", rd(0), 32'h00001111);
`endif
        set_wr(0, 1'b0, 5'd7, 32'h00001111);
        tick();
        check("conf_ack2", {30'b0, bus.wr_ack}, 32'd2);
        check("conf_final", rd(0), 32'h00002222);
        set_wr(1, 1'b0, 5'd7, 32'h00002222);
        tick();
        check("conf_ack_clr", {30'b0, bus.wr_ack}, 32'd0);

        // Register 0 write is acked but discarded
        set_rd(0, 5'd0);
        set_wr(1, 1'b1, 5'd0, 32'hFFFFFFFF);
        #1;
        check("r0_same", rd(0), 32'h0);
        tick();
        check("r0_ack", {30'b0, bus.wr_ack}, 32'd2);
        check("r0_read", rd(0), 32'h0);
        set_wr(1, 1'b0, 5'd0, 32'hFFFFFFFF);
        tick();

        // Port writing r0 still blocks a higher port targeting r0
        set_wr(0, 1'b1, 5'd0, 32'h0000AAAA);
        set_wr(1, 1'b1, 5'd0, 32'h0000BBBB);
        tick();
        check("r0_prio_ack1", {30'b0, bus.wr_ack}, 32'd1);
        set_wr(0, 1'b0, 5'd0, 32'h0000AAAA);
        tick();
        check("r0_prio_ack2", {30'b0, bus.wr_ack}, 32'd2);
        check("r0_prio_read", rd(0), 32'h0);
        set_wr(1, 1'b0, 5'd0, 32'h0000BBBB);
        tick();

        // Held request one cycle past ack: single commit, single ack
        set_rd(1, 5'd3);
        set_wr(0, 1'b1, 5'd3, 32'hCAFE0003);
        tick();
        check("held_ack", {30'b0, bus.wr_ack}, 32'd1);
        check("held_rd1", rd(1), 32'hCAFE0003);
        set_wr(0, 1'b1, 5'd3, 32'hBAD00003);
        tick();
        set_wr(0, 1'b0, 5'd3, 32'h0);
        #1;
        check("held_no_2nd_ack", {30'b0, bus.wr_ack}, 32'd0);
        check("held_rd2", rd(1), 32'hCAFE0003);
        tick();
        check("held_ack_clr", {30'b0, bus.wr_ack}, 32'd0);
        check("held_rd3", rd(1), 32'hCAFE0003);

        // Preload including top register
        wr_single(0, 5'd31, 32'hF00D001F);
        wr_single(1, 5'd10, 32'h0000000A);
        set_rd(0, 5'd31);
        set_rd(1, 5'd10);
        #1;
        check("pre_r31", rd(0), 32'hF00D001F);
        check("pre_r10", rd(1), 32'h0000000A);

        // Reset mid-run with a request held through the clear
        rst = 1'b1;
        set_wr(0, 1'b1, 5'd2, 32'h00000077);
        tick();
        check("rst2_init_done", {31'b0, bus.init_done}, 32'd0);
        check("rst2_ack", {30'b0, bus.wr_ack}, 32'd0);
        check("rst2_rd0", rd(0), 32'h0);
        tick();
        rst = 1'b0;
        wait_init(n, ack_seen);
        check("clear2_len", n, 32'd31);
        check("clear2_no_ack", {31'b0, ack_seen}, 32'd0);
        tick();
        check("post_clear_ack", {30'b0, bus.wr_ack}, 32'd1);
        set_wr(0, 1'b0, 5'd2, 32'h00000077);
        #1;
        for (int i = 0; i < 32; i++) begin
            set_rd(0, 5'(i));
            set_rd(1, 5'(31 - i));
            #1;
            check("clear_rd0", rd(0), (i == 2) ? 32'h77 : 32'h0);
            check("clear_rd1", rd(1), ((31 - i) == 2) ? 32'h77 : 32'h0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
